channel_in_acc_tree: RTL and testbench
======================================

Name: channel_in_acc_tree

Overview:
Parametrised successor to the fixed 4-input channel-in adder. Sums CH_IN_NUM channel partial-product vectors through a registered SIMD adder tree of log2(CH_IN_NUM) levels. It then accumulates the tree result across a framed group of beats (multiple input-channel passes) and emits one valid result per group. Sits between the multiplier array and the bias/quantisation stage of the conv datapath.

Parameters:
CH_IN_NUM, 8, channel vectors summed per beat; power of 2, 1..64
PICTURE_NUM, 8, SIMD lanes per channel vector (`PICTURE_NUM)
LANE_W, 32, bits per lane, signed two's complement (`WIDTH_DATA_OUT*2)
CNT_W, 12, width of the beat counter
SAT_EN, 0, 0 = wrap modulo 2^LANE_W in the accumulator add; 1 = per-lane signed saturation in the accumulator add

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  beat present on data_in
in_first  in  1  beat is the first of a group (qualified by in_valid)
in_last  in  1  beat is the last of a group (qualified by in_valid)
data_in  in  CH_IN_NUM*PICTURE_NUM*LANE_W  channel k occupies slice k*PICTURE_NUM*LANE_W upward; lane j of each channel occupies j*LANE_W upward
out_valid  out  1  one-cycle pulse, result valid
out_data  out  PICTURE_NUM*LANE_W  accumulated group sum per lane
out_beats  out  CNT_W  number of valid beats in the group (saturates at 2^CNT_W-1)

Behaviour:
- Single clock domain (clk); rst is synchronous and active-high. No backpressure; the downstream stage must always accept.
- Reset values: out_valid=0, out_data=0, out_beats=0. Accumulator=0, beat counter=0, all pipeline valid/first/last bits=0.
- Tree: level n adds pairs (2i, 2i+1) lane-wise, registered, wrap modulo 2^LANE_W. L=log2(CH_IN_NUM) levels. in_valid, in_first and in_last are pipelined alongside the data.
- CH_IN_NUM=1: L=0, tree is a pass-through wire.
- Accumulator stage acts on tree-output valid (tv):
  - tv & tfirst: acc <= tree_sum; cnt <= 1.
  - tv & !tfirst: acc <= acc + tree_sum (wrap or saturate per SAT_EN); cnt <= cnt+1, saturating.
  - tv & tlast: out_data <= the new acc value; out_beats <= the new cnt; out_valid <= 1 for exactly one cycle.
  - !tv: acc and cnt hold; out_valid <= 0; out_data and out_beats hold their last values.
- Latency: last input beat at cycle t gives out_valid at t+L+1.
- Throughput: one beat per cycle. Bubbles (in_valid=0) are allowed anywhere and do not disturb the result.
- first & last on the same beat: a single-beat group; out = tree_sum, out_beats=1.
- A beat without first after reset, or after a completed group, accumulates onto the current acc (0 after reset; otherwise the previous group's sum). This is defined behaviour; framing is the upstream's responsibility.
- Back-to-back groups (last of A, first of B on consecutive cycles) produce consecutive out_valid pulses with no mixing.
- Saturation (SAT_EN=1): the per-lane sum is clamped to [-2^(LANE_W-1), 2^(LANE_W-1)-1]. The tree itself always wraps.
- rst mid-group: all in-flight beats are discarded; no out_valid for that group; the next in_first group is correct.

Decomposition:
- Shared package/include: LANE_W, PICTURE_NUM and CH_IN_NUM defaults, a clog2 helper, and lane slice index constants.
- One natural sub-module: simd_add_reg. Per-lane registered adder with valid/first/last sideband, parameterised by PICTURE_NUM and LANE_W. It is instantiated CH_IN_NUM-1 times by generate loops over levels.
- The accumulator stage, with its saturation logic, lives in the top module.

Test Plan:
All scenarios use CH_IN_NUM=4, PICTURE_NUM=2, LANE_W=16, CNT_W=4 unless stated.
- Single beat, first=last=1, lane0 channels 1,2,3,4, lane1 channels -1,-1,-1,-1, at cycle t -> out_valid at t+3, lane0=10, lane1=-4, out_beats=1.
- Three-beat group with lane0 tree sums 10, 20, -5 -> one out_valid, lane0=25, out_beats=3; no out_valid on beats 1-2.
- Lane0 beats summing 32767 then 1: SAT_EN=0 -> out=-32768; SAT_EN=1 -> out=32767. Beats summing -32768 then -1 with SAT_EN=1 -> -32768.
- Back-to-back groups: A={5}, B={7,8}, no gaps -> out_valid pulses carrying 5 (beats 1) then 15 (beats 2). Then a 17-beat group -> out_beats=15 (saturated).
- Bubbles: same 3-beat group as above with in_valid=0 gaps of 2 cycles -> lane0=25, and out_valid 3 cycles after the last beat.
- rst asserted one cycle after beat 2 of a 3-beat group -> no out_valid, outputs 0. Then a group {3} -> out=3, out_beats=1.
- CH_IN_NUM=1 build: a {9} single-beat group -> out_valid 1 cycle later with 9.

Source files
------------

// File: rtl/channel_in_acc_tree_pkg.sv
// Shared defaults, sideband type and slice-index helpers for the channel-in
// adder tree and its accumulator.
package channel_in_acc_tree_pkg;

  localparam int CH_IN_NUM_DEF   = 8;
  localparam int PICTURE_NUM_DEF = 8;
  localparam int LANE_W_DEF      = 32;
  localparam int CNT_W_DEF       = 12;

  // Beat framing carried alongside the data through every tree level.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } sb_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int lane_lo(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

  function automatic int chan_lo(input int ch, input int picture_num, input int lane_w);
    return ch * picture_num * lane_w;
  endfunction

endpackage

// File: rtl/channel_in_acc_tree_if.sv
// Beat input / group result bus of the channel-in accumulation tree.
interface channel_in_acc_tree_if
  import channel_in_acc_tree_pkg::*;
#(
  parameter int CH_IN_NUM   = CH_IN_NUM_DEF,
  parameter int PICTURE_NUM = PICTURE_NUM_DEF,
  parameter int LANE_W      = LANE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
);

  // Handshake: no ready/backpressure. A beat is taken on every clk edge where
  // in_valid=1 (in_first/in_last only meaningful then); out_valid is a
  // one-cycle pulse that the consumer must accept unconditionally.
  logic                                   in_valid;
  logic                                   in_first;
  logic                                   in_last;
  logic [CH_IN_NUM*PICTURE_NUM*LANE_W-1:0] data_in;
  logic                                   out_valid;
  logic [PICTURE_NUM*LANE_W-1:0]          out_data;
  logic [CNT_W-1:0]                       out_beats;

  modport slave (
    input  in_valid, in_first, in_last, data_in,
    output out_valid, out_data, out_beats
  );

  modport master (
    output in_valid, in_first, in_last, data_in,
    input  out_valid, out_data, out_beats
  );

endinterface

// File: rtl/channel_in_acc_tree_simd_add_reg.sv
// simd_add_reg stage: one registered lane-wise wrap-around add of two channel
// vectors, with the beat framing registered alongside.
module channel_in_acc_tree_simd_add_reg
  import channel_in_acc_tree_pkg::*;
#(
  parameter int PICTURE_NUM = PICTURE_NUM_DEF,
  parameter int LANE_W      = LANE_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PICTURE_NUM*LANE_W-1:0] a,
  input  logic [PICTURE_NUM*LANE_W-1:0] b,
  input  sb_t                           sb_a,
  input  sb_t                           sb_b,
  output logic [PICTURE_NUM*LANE_W-1:0] sum,
  output sb_t                           sb_o
);

  // Both children carry identical framing; combining them keeps every bit live.
  always_ff @(posedge clk) begin
    if (rst) sb_o <= '0;
    else     sb_o <= sb_a & sb_b;
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < PICTURE_NUM; j++) begin
      sum[lane_lo(j, LANE_W) +: LANE_W] <= a[lane_lo(j, LANE_W) +: LANE_W]
                                         + b[lane_lo(j, LANE_W) +: LANE_W];
    end
  end

endmodule

// File: rtl/channel_in_acc_tree.sv
// Registered SIMD adder tree over CH_IN_NUM channel vectors followed by a
// per-group accumulator that emits one result pulse per framed group.
module channel_in_acc_tree
  import channel_in_acc_tree_pkg::*;
#(
  parameter int CH_IN_NUM   = CH_IN_NUM_DEF,
  parameter int PICTURE_NUM = PICTURE_NUM_DEF,
  parameter int LANE_W      = LANE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SAT_EN      = 0
) (
  input logic                  clk,
  input logic                  rst,
  channel_in_acc_tree_if.slave bus
);

  localparam int VW = PICTURE_NUM * LANE_W;
  localparam logic [LANE_W-1:0] SAT_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_MIN = {1'b1, {(LANE_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  // Heap-ordered tree: node i sums nodes 2i and 2i+1, leaves sit at
  // CH_IN_NUM..2*CH_IN_NUM-1 and the root is node 1 (a leaf when CH_IN_NUM=1).
  logic [VW-1:0] node_d  [2*CH_IN_NUM-1:1];
  sb_t           node_sb [2*CH_IN_NUM-1:1];
  sb_t           leaf_sb;

  assign leaf_sb = {bus.in_valid, bus.in_valid & bus.in_first, bus.in_valid & bus.in_last};

  for (genvar k = 0; k < CH_IN_NUM; k++) begin : g_leaf
    assign node_d[CH_IN_NUM+k]  = bus.data_in[chan_lo(k, PICTURE_NUM, LANE_W) +: VW];
    assign node_sb[CH_IN_NUM+k] = leaf_sb;
  end

  for (genvar i = 1; i < CH_IN_NUM; i++) begin : g_node
    channel_in_acc_tree_simd_add_reg #(
      .PICTURE_NUM (PICTURE_NUM),
      .LANE_W      (LANE_W)
    ) u_add (
      .clk  (clk),
      .rst  (rst),
      .a    (node_d[2*i]),
      .b    (node_d[2*i+1]),
      .sb_a (node_sb[2*i]),
      .sb_b (node_sb[2*i+1]),
      .sum  (node_d[i]),
      .sb_o (node_sb[i])
    );
  end

  logic [VW-1:0]     root_d;
  sb_t               root_sb;
  logic [VW-1:0]     acc;
  logic [VW-1:0]     acc_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [LANE_W-1:0] a_l;
  logic [LANE_W-1:0] b_l;
  logic [LANE_W:0]   s_l;

  assign root_d  = node_d[1];
  assign root_sb = node_sb[1];

  // Sign-extended add per lane; a sign mismatch in the top two bits is overflow.
  always_comb begin
    acc_nxt = '0;
    a_l     = '0;
    b_l     = '0;
    s_l     = '0;
    for (int j = 0; j < PICTURE_NUM; j++) begin
      a_l = acc[lane_lo(j, LANE_W) +: LANE_W];
      b_l = root_d[lane_lo(j, LANE_W) +: LANE_W];
      s_l = {a_l[LANE_W-1], a_l} + {b_l[LANE_W-1], b_l};
      if (root_sb.first)
        acc_nxt[lane_lo(j, LANE_W) +: LANE_W] = b_l;
      else if ((SAT_EN != 0) && (s_l[LANE_W] != s_l[LANE_W-1]))
        acc_nxt[lane_lo(j, LANE_W) +: LANE_W] = s_l[LANE_W] ? SAT_MIN : SAT_MAX;
      else
        acc_nxt[lane_lo(j, LANE_W) +: LANE_W] = s_l[LANE_W-1:0];
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    if (root_sb.first)       cnt_nxt = CNT_W'(1);
    else if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_beats <= '0;
    end else begin
      bus.out_valid <= root_sb.valid & root_sb.last;
      if (root_sb.valid) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        if (root_sb.last) begin
          bus.out_data  <= acc_nxt;
          bus.out_beats <= cnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_in_acc_tree.sv
// Drives one random/directed beat stream into three builds (4ch wrap, 4ch
// saturate, 1ch wrap) and scoreboards every group result and its arrival cycle.
module tb_channel_in_acc_tree;
  import channel_in_acc_tree_pkg::*;

  localparam int CH = 4;
  localparam int P  = 2;
  localparam int W  = 16;
  localparam int CW = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;

  channel_in_acc_tree_if #(.CH_IN_NUM(CH), .PICTURE_NUM(P), .LANE_W(W), .CNT_W(CW)) bus0 ();
  channel_in_acc_tree_if #(.CH_IN_NUM(CH), .PICTURE_NUM(P), .LANE_W(W), .CNT_W(CW)) bus1 ();
  channel_in_acc_tree_if #(.CH_IN_NUM(1),  .PICTURE_NUM(P), .LANE_W(W), .CNT_W(CW)) bus2 ();

  channel_in_acc_tree #(.CH_IN_NUM(CH), .PICTURE_NUM(P), .LANE_W(W), .CNT_W(CW), .SAT_EN(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  channel_in_acc_tree #(.CH_IN_NUM(CH), .PICTURE_NUM(P), .LANE_W(W), .CNT_W(CW), .SAT_EN(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  channel_in_acc_tree #(.CH_IN_NUM(1),  .PICTURE_NUM(P), .LANE_W(W), .CNT_W(CW), .SAT_EN(0))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  int ch_val [CH][P];
  int m_acc  [3][P];
  int m_cnt  [3];

  logic [35:0] exp_q0[$], exp_q1[$], exp_q2[$];
  int          exp_t0[$], exp_t1[$], exp_t2[$];

  function automatic int wrap16(input int x);
    logic [15:0] t;
    t = x[15:0];
    return int'($signed(t));
  endfunction

  function automatic int clamp16(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_cnt[d] = 0;
      for (int j = 0; j < P; j++) m_acc[d][j] = 0;
    end
  endtask

  task automatic model_beat(input bit f, input bit l);
    int nch;
    int s;
    logic [35:0] e;
    for (int d = 0; d < 3; d++) begin
      nch = (d == 2) ? 1 : CH;
      for (int j = 0; j < P; j++) begin
        s = 0;
        for (int k = 0; k < nch; k++) s += ch_val[k][j];
        s = wrap16(s);
        if (f)           m_acc[d][j] = s;
        else if (d == 1) m_acc[d][j] = clamp16(m_acc[d][j] + s);
        else             m_acc[d][j] = wrap16(m_acc[d][j] + s);
      end
      if (f)               m_cnt[d] = 1;
      else if (m_cnt[d] < 15) m_cnt[d] = m_cnt[d] + 1;
      if (l) begin
        e = {4'(m_cnt[d]), 16'(m_acc[d][1]), 16'(m_acc[d][0])};
        case (d)
          0: begin exp_q0.push_back(e); exp_t0.push_back(cyc + clog2(nch) + 1); end
          1: begin exp_q1.push_back(e); exp_t1.push_back(cyc + clog2(nch) + 1); end
          default: begin exp_q2.push_back(e); exp_t2.push_back(cyc + clog2(nch) + 1); end
        endcase
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s dut%0d: got %0h, want %0h (cycle %0d)", name, d, act, exp, cyc);
  endtask

  task automatic check_out(input int d, input logic [35:0] act);
    bit          have;
    logic [35:0] e;
    int          et;
    have = 0;
    e    = '0;
    et   = 0;
    case (d)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); et = exp_t0.pop_front(); have = 1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); et = exp_t1.pop_front(); have = 1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); et = exp_t2.pop_front(); have = 1; end
    endcase
    check("out_valid_expected", d, 64'(have), 64'd1);
    if (have) begin
      check("out_data", d, 64'(act[31:0]), 64'(e[31:0]));
      check("out_beats", d, 64'(act[35:32]), 64'(e[35:32]));
      check("latency", d, 64'(cyc), 64'(et));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.out_valid) check_out(0, {bus0.out_beats, bus0.out_data});
      if (bus1.out_valid) check_out(1, {bus1.out_beats, bus1.out_data});
      if (bus2.out_valid) check_out(2, {bus2.out_beats, bus2.out_data});
    end
  end

  task automatic check_reset_vals();
    check("rst_out_valid", 0, 64'(bus0.out_valid), 64'd0);
    check("rst_out_data",  0, 64'(bus0.out_data),  64'd0);
    check("rst_out_beats", 0, 64'(bus0.out_beats), 64'd0);
    check("rst_out_valid", 1, 64'(bus1.out_valid), 64'd0);
    check("rst_out_data",  1, 64'(bus1.out_data),  64'd0);
    check("rst_out_beats", 1, 64'(bus1.out_beats), 64'd0);
    check("rst_out_valid", 2, 64'(bus2.out_valid), 64'd0);
    check("rst_out_data",  2, 64'(bus2.out_data),  64'd0);
    check("rst_out_beats", 2, 64'(bus2.out_beats), 64'd0);
  endtask

  task automatic check_drained();
    check("pending_results", 0, 64'(exp_q0.size()), 64'd0);
    check("pending_results", 1, 64'(exp_q1.size()), 64'd0);
    check("pending_results", 2, 64'(exp_q2.size()), 64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input bit v, input bit f, input bit l);
    logic [CH*P*W-1:0] d;
    d = '0;
    for (int k = 0; k < CH; k++)
      for (int j = 0; j < P; j++)
        d[(k*P+j)*W +: W] = 16'(ch_val[k][j]);
    bus0.in_valid = v; bus0.in_first = f; bus0.in_last = l; bus0.data_in = d;
    bus1.in_valid = v; bus1.in_first = f; bus1.in_last = l; bus1.data_in = d;
    bus2.in_valid = v; bus2.in_first = f; bus2.in_last = l; bus2.data_in = d[P*W-1:0];
  endtask

  task automatic drive(input bit v, input bit f, input bit l);
    @(posedge clk);
    #1;
    set_inputs(v, f, l);
    if (v) model_beat(f, l);
  endtask

  task automatic rand_vals();
    for (int k = 0; k < CH; k++)
      for (int j = 0; j < P; j++)
        ch_val[k][j] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic set_lane0(input int c0, input int c1, input int c2, input int c3);
    rand_vals();
    ch_val[0][0] = c0; ch_val[1][0] = c1; ch_val[2][0] = c2; ch_val[3][0] = c3;
  endtask

  // Bubbles carry random data and random framing bits that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      rand_vals();
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_inputs(1'b0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_vals();
    check_drained();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  len;
    bit  no_first;
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    model_reset();
    for (int k = 0; k < CH; k++) for (int j = 0; j < P; j++) ch_val[k][j] = 0;
    set_inputs(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b0;

    // single-beat group
    set_lane0(1, 2, 3, 4);
    for (int k = 0; k < CH; k++) ch_val[k][1] = -1;
    drive(1, 1, 1);
    idle(5);

    // three-beat group, tree sums 10, 20, -5
    set_lane0(10, 0, 0, 0);  drive(1, 1, 0);
    set_lane0(5, 5, 5, 5);   drive(1, 0, 0);
    set_lane0(-5, 0, 0, 0);  drive(1, 0, 1);
    idle(5);

    // overflow at both ends of the lane range
    set_lane0(32767, 0, 0, 0);  drive(1, 1, 0);
    set_lane0(1, 0, 0, 0);      drive(1, 0, 1);
    set_lane0(-32768, 0, 0, 0); drive(1, 1, 0);
    set_lane0(-1, 0, 0, 0);     drive(1, 0, 1);
    idle(5);

    // back-to-back groups, then a beat-count saturation group
    set_lane0(5, 0, 0, 0); drive(1, 1, 1);
    set_lane0(7, 0, 0, 0); drive(1, 1, 0);
    set_lane0(8, 0, 0, 0); drive(1, 0, 1);
    for (int b = 0; b < 17; b++) begin
      set_lane0(int'($urandom_range(0, 20)), 1, 2, 3);
      drive(1, b == 0, b == 16);
    end
    idle(5);

    // three-beat group with two-cycle bubbles
    set_lane0(10, 0, 0, 0); drive(1, 1, 0); idle(2);
    set_lane0(5, 5, 5, 5);  drive(1, 0, 0); idle(2);
    set_lane0(-5, 0, 0, 0); drive(1, 0, 1);
    idle(6);

    // reset one cycle after beat 2 of a three-beat group
    set_lane0(10, 0, 0, 0); drive(1, 1, 0);
    set_lane0(5, 5, 5, 5);  drive(1, 0, 0);
    do_reset();
    set_lane0(3, 0, 0, 0);  drive(1, 1, 1);
    idle(5);

    // random groups, occasionally without a leading first flag
    for (int g = 0; g < 60; g++) begin
      len      = $urandom_range(1, 5);
      no_first = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        rand_vals();
        drive(1, (b == 0) && !no_first, b == len - 1);
      end
    end
    idle(10);
    check_drained();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
